pulse_stretch_multi: RTL and testbench
======================================

# pulse_stretch_multi

Multi-channel, runtime-programmable pulse stretcher with per-channel counters.
Each channel turns a trigger on its `in` bit into an output pulse of programmable length. Triggers can be level or rising-edge, and pulses can be retriggerable or non-retriggerable.
It sits between event sources (sensor strobes, error flags, handshake blips) and slow consumers such as LEDs, IRQ lines or cross-domain synchronisers.
An optional hold-off enforces a minimum low gap between consecutive pulses.

## Interface
Parameters:
- `CH`, 4: number of independent channels.
- `WIDTH_MAX`, 255: maximum programmable pulse width, in cycles (≥1).
- `CNTR_W`, `$clog2(WIDTH_MAX+1)`: counter and width-port bit width (localparam, not overridable).

Ports:
- `clk`  in  1  clock; all logic on its rising edge.
- `nrst`  in  1  reset; synchronous, active-low.
- `in`  in  CH  per-channel trigger inputs.
- `width`  in  CNTR_W  pulse width, shared by all channels; sampled per channel at its trigger edge.
- `retrig`  in  1  mode select: 1 = retriggerable, 0 = non-retriggerable.
- `edge_mode`  in  1  trigger select: 1 = rising edge of `in`, 0 = level of `in`.
- `holdoff`  in  CNTR_W  minimum low gap, in cycles. Present only with `PULSE_STRETCH_HOLDOFF_EN`.
- `out`  out  CH  stretched pulses; registered.
- `busy`  out  1  OR over channels of (state ≠ IDLE); registered.

## Operation
- Reset (`nrst`=0 at an edge):
  - all channels go to IDLE; counters, `in_d`, `out` and `busy` go to 0;
  - reset mid-pulse drops `out` after that edge, with no completion.
- Trigger detection, per channel:
  - `trig = in` when `edge_mode`=0; `trig = in & ~in_d` when `edge_mode`=1;
  - `in_d` updates every cycle in every state. Edges arriving while a trigger is ignored are lost.
- Effective width `w = min(width, WIDTH_MAX)`. Effective hold-off `h = min(holdoff, WIDTH_MAX)`, computed the same way.
- Per-channel FSM:
  - **IDLE**:
    - `trig` with `w`≥1: load `cnt=w`, go to PULSE;
    - `trig` with `w`=0: ignored, stay in IDLE.
  - **PULSE** (`out`=1):
    - `retrig`=1 and `trig` and `w`≥1: reload `cnt=w`;
    - else if `cnt`=1: go to HOLD (`cnt=h`) when `h`≥1, otherwise go to IDLE;
    - else: decrement `cnt`;
    - `retrig`=0: `trig` is ignored in PULSE.
  - **HOLD** (macro only; `out`=0): decrement `cnt`. At `cnt`=1:
    - with `trig` and `w`≥1: load `cnt=w`, go directly to PULSE;
    - otherwise: go to IDLE;
    - `trig` is ignored in every other HOLD cycle, regardless of `retrig`.
- `width`, `holdoff`, `retrig` and `edge_mode` may change at any time:
  - a running PULSE keeps its loaded count, except on a retrigger reload;
  - a mode change takes effect at the next evaluated edge.
- Channels are fully independent. Simultaneous triggers on all channels are each handled in the same cycle.

## Timing
- Cycle n denotes the period following clock edge n.
- Latency: `trig` sampled at edge n gives `out`=1 in cycle n.
- A single accepted trigger gives exactly `w` high cycles: n … n+w−1.
- Retriggerable mode: `out` stays high until `w` cycles after the last accepted trigger.
- Non-retriggerable mode with `in` held high in level mode, and no hold-off:
  - the pattern is `w` high, 1 low, repeating (period `w`+1);
  - the low cycle is the IDLE cycle.
- With hold-off `h`≥1: the low gap between pulses is exactly `h` cycles when a trigger is pending at the HOLD exit.
- `h`=0 and `h`=1 both give a 1-cycle gap in level mode.
- `busy` follows the per-channel states with the same timing as `out`.

## Configuration
- `PULSE_STRETCH_HOLDOFF_EN` defined:
  - the `holdoff` port exists;
  - the HOLD state is implemented;
  - `busy` includes HOLD.
- Not defined:
  - no `holdoff` port and no HOLD state;
  - PULSE exits straight to IDLE at `cnt`=1;
  - all other behaviour is identical.

## Test plan
- Single-cycle `in[0]` at edge 10, `width`=3, `retrig`=0 → `out[0]` high in cycles 10–12 and low from 13; `busy` matches; other channels stay 0.
- Retrigger: `retrig`=1, `width`=3, `in[1]` pulses at edges 10 and 12 → `out[1]` high 10–14. The same stimulus with `retrig`=0 → high 10–12 only.
- Level vs. edge: `in[2]` held high for edges 10–30, `width`=3, `retrig`=0:
  - `edge_mode`=0 → high 10–12, 14–16, 18–20, …;
  - `edge_mode`=1 → a single pulse, high 10–12.
- Boundaries:
  - `width`=0 with `in` asserted → `out` never rises;
  - `width`=2^CNTR_W−1 with `WIDTH_MAX`=200 → pulse of exactly 200 cycles;
  - `width` changed from 3 to 8 at edge 11 during the 10–12 pulse → pulse unchanged.
- Reset mid-pulse: `width`=10, trigger at edge 10, `nrst`=0 at edge 13 → `out`=0 and `busy`=0 from cycle 13; `in_d` cleared, so a held `in` with `edge_mode`=1 re-triggers after reset is released.
- Macro on: `holdoff`=2, `width`=3, level `in` held, `retrig`=0 → high 10–12, low 13–14, high 15–17, low 18–19. Edge triggers at edges 13 and 14 are ignored.

Source files
------------

// File: rtl/pulse_stretch_multi.sv
// Multi-channel programmable pulse stretcher with level/edge triggering and retrigger control.
// Optional minimum low gap between pulses is enabled by defining PULSE_STRETCH_HOLDOFF_EN.
module pulse_stretch_multi #(
    parameter  int CH        = 4,
    parameter  int WIDTH_MAX = 255,
    localparam int CNTR_W    = $clog2(WIDTH_MAX + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [CH-1:0]     in,
    input  logic [CNTR_W-1:0] width,
    input  logic              retrig,
    input  logic              edge_mode,
`ifdef PULSE_STRETCH_HOLDOFF_EN
    input  logic [CNTR_W-1:0] holdoff,
`endif
    output logic [CH-1:0]     out,
    output logic              busy
);

`ifdef PULSE_STRETCH_HOLDOFF_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1
    } state_t;
`endif

    localparam logic [CNTR_W-1:0] CNT_ZERO = {CNTR_W{1'b0}};
    localparam logic [CNTR_W-1:0] CNT_ONE  = {{(CNTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNTR_W-1:0] CNT_MAX  = CNTR_W'(WIDTH_MAX);

    // Saturate a programmed count at the largest supported pulse length.
    function automatic logic [CNTR_W-1:0] clamp_cnt(input logic [CNTR_W-1:0] v);
        logic [CNTR_W-1:0] r;
        if (v > CNT_MAX) begin
            r = CNT_MAX;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [CNTR_W-1:0] w_s;
    logic              w_nz_s;
    logic [CH-1:0]     in_d_r;
    logic [CH-1:0]     trig_s;
    logic [CH-1:0]     pulse_nxt_s;
    logic [CH-1:0]     active_nxt_s;
    logic [CH-1:0]     out_r;
    logic              busy_r;
`ifdef PULSE_STRETCH_HOLDOFF_EN
    logic [CNTR_W-1:0] h_s;
`endif

    // Effective width/hold-off and per-channel trigger qualification.
    always_comb begin
        w_s    = clamp_cnt(width);
        w_nz_s = (w_s != CNT_ZERO);
`ifdef PULSE_STRETCH_HOLDOFF_EN
        h_s    = clamp_cnt(holdoff);
`endif
        if (edge_mode) begin
            trig_s = in & ~in_d_r;
        end else begin
            trig_s = in;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        state_t            state_r;
        state_t            state_nxt_s;
        logic [CNTR_W-1:0] cnt_r;
        logic [CNTR_W-1:0] cnt_nxt_s;

        // Channel next-state: retrigger reload wins over the end-of-pulse exit.
        always_comb begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
            case (state_r)
                ST_IDLE: begin
                    if (trig_s[g] && w_nz_s) begin
                        state_nxt_s = ST_PULSE;
                        cnt_nxt_s   = w_s;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end
                end
                ST_PULSE: begin
                    if (retrig && trig_s[g] && w_nz_s) begin
                        cnt_nxt_s = w_s;
                    end else if (cnt_r == CNT_ONE) begin
`ifdef PULSE_STRETCH_HOLDOFF_EN
                        if (h_s != CNT_ZERO) begin
                            state_nxt_s = ST_HOLD;
                            cnt_nxt_s   = h_s;
                        end else begin
                            state_nxt_s = ST_IDLE;
                            cnt_nxt_s   = CNT_ZERO;
                        end
`else
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = CNT_ZERO;
`endif
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_ONE;
                    end
                end
`ifdef PULSE_STRETCH_HOLDOFF_EN
                ST_HOLD: begin
                    if (cnt_r == CNT_ONE) begin
                        if (trig_s[g] && w_nz_s) begin
                            state_nxt_s = ST_PULSE;
                            cnt_nxt_s   = w_s;
                        end else begin
                            state_nxt_s = ST_IDLE;
                            cnt_nxt_s   = CNT_ZERO;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_ONE;
                    end
                end
`endif
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end

        // Channel state and counter registers.
        always_ff @(posedge clk) begin
            if (!nrst) begin
                state_r <= ST_IDLE;
                cnt_r   <= CNT_ZERO;
            end else begin
                state_r <= state_nxt_s;
                cnt_r   <= cnt_nxt_s;
            end
        end

        assign pulse_nxt_s[g]  = (state_nxt_s == ST_PULSE);
        assign active_nxt_s[g] = (state_nxt_s != ST_IDLE);
    end

    // Outputs are registered from next-state so they align with the state they report.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            in_d_r <= {CH{1'b0}};
            out_r  <= {CH{1'b0}};
            busy_r <= 1'b0;
        end else begin
            in_d_r <= in;
            out_r  <= pulse_nxt_s;
            busy_r <= |active_nxt_s;
        end
    end

    assign out  = out_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_pulse_stretch_multi.sv
// Scoreboard bench for pulse_stretch_multi: a timestamp-based reference model queues the
// expected out/busy per cycle; an independent monitor compares them after each clock edge.
module tb_pulse_stretch_multi;
    localparam int CH   = 4;
    localparam int WMAX = 200;

    typedef struct packed {
        logic [CH-1:0] o;
        logic          b;
    } exp_t;

    logic          clk = 1'b0;
    logic          nrst_s = 1'b0;
    logic [CH-1:0] in_s = '0;
    logic [7:0]    width_s = 8'd3;
    logic          retrig_s = 1'b0;
    logic          edge_s = 1'b0;
    logic [7:0]    holdoff_s = 8'd0;
    logic [CH-1:0] out_w;
    logic          busy_w;

    exp_t          q[$];
    int            n_vec = 0;
    int            n_err = 0;

    longint        pend[CH];
    longint        hend[CH];
    logic [CH-1:0] prev_in = '0;
    longint        cyc = 0;

    always #5 clk = ~clk;

    pulse_stretch_multi #(.CH(CH), .WIDTH_MAX(WMAX)) dut (
        .clk       (clk),
        .nrst      (nrst_s),
        .in        (in_s),
        .width     (width_s),
        .retrig    (retrig_s),
        .edge_mode (edge_s),
`ifdef PULSE_STRETCH_HOLDOFF_EN
        .holdoff   (holdoff_s),
`endif
        .out       (out_w),
        .busy      (busy_w)
    );

    // Reference: each channel is described by the last high cycle (pend) and the last
    // non-idle cycle (hend). Called at the negedge with inputs for the coming edge.
    task automatic tick();
        int     w;
        int     h;
        longint c;
        logic   t;
        exp_t   e;
        cyc++;
        c = cyc - 1;
        w = (int'(width_s) > WMAX) ? WMAX : int'(width_s);
`ifdef PULSE_STRETCH_HOLDOFF_EN
        h = (int'(holdoff_s) > WMAX) ? WMAX : int'(holdoff_s);
`else
        h = 0;
`endif
        if (!nrst_s) begin
            for (int ch = 0; ch < CH; ch++) begin
                pend[ch] = -1000;
                hend[ch] = -1000;
            end
            prev_in = '0;
        end else begin
            for (int ch = 0; ch < CH; ch++) begin
                t = edge_s ? (in_s[ch] & ~prev_in[ch]) : in_s[ch];
                if (c <= pend[ch]) begin
                    if (retrig_s && t && w > 0) begin
                        pend[ch] = cyc + w - 1;
                        hend[ch] = pend[ch];
                    end else if (c == pend[ch]) begin
                        hend[ch] = pend[ch] + h;
                    end
                end else if (c <= hend[ch]) begin
                    if (c == hend[ch] && t && w > 0) begin
                        pend[ch] = cyc + w - 1;
                        hend[ch] = pend[ch];
                    end
                end else if (t && w > 0) begin
                    pend[ch] = cyc + w - 1;
                    hend[ch] = pend[ch];
                end
            end
            prev_in = in_s;
        end
        e.b = 1'b0;
        for (int ch = 0; ch < CH; ch++) begin
            e.o[ch] = (cyc <= pend[ch]);
            if (cyc <= hend[ch]) e.b = 1'b1;
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: one comparison per cycle that has a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (out_w !== e.o || busy_w !== e.b) begin
                    n_err++;
                    $display("FAIL out_busy @%0t: got out=%b busy=%b, expected out=%b busy=%b",
                             $time, out_w, busy_w, e.o, e.b);
                end
            end
        end
    end

    initial begin
        int k;
        @(negedge clk);
        nrst_s = 1'b0;
        run(3);
        nrst_s = 1'b1;
        run(4);

        // single-cycle trigger, width 3, non-retriggerable
        width_s = 8'd3; retrig_s = 1'b0; edge_s = 1'b0;
        in_s = 4'b0001; tick(); in_s = '0; run(6);

        // retrigger vs non-retrigger on channel 1
        for (int m = 0; m < 2; m++) begin
            retrig_s = (m == 0);
            in_s = 4'b0010; tick(); in_s = '0; tick();
            in_s = 4'b0010; tick(); in_s = '0; run(6);
        end

        // level vs edge with held input on channel 2
        retrig_s = 1'b0;
        for (int m = 0; m < 2; m++) begin
            edge_s = (m == 1);
            in_s = 4'b0100; run(21); in_s = '0; run(5);
        end

        // width 0 never fires
        edge_s = 1'b0; width_s = 8'd0; in_s = 4'b1111; run(10); in_s = '0; run(2);

        // width above WIDTH_MAX clamps
        width_s = 8'd255; in_s = 4'b1000; tick(); in_s = '0; run(205);

        // width change mid-pulse leaves the running pulse alone
        width_s = 8'd3; in_s = 4'b0001; tick(); in_s = '0; width_s = 8'd8; run(6);

        // reset mid-pulse, then held input re-triggers in edge mode
        width_s = 8'd10; edge_s = 1'b1; in_s = 4'b0001; run(3);
        nrst_s = 1'b0; tick(); nrst_s = 1'b1; run(14); in_s = '0; run(12);

        // hold-off gap in level mode (plain w-high/1-low pattern without the macro)
        edge_s = 1'b0; width_s = 8'd3; holdoff_s = 8'd2; in_s = 4'b0001; run(15);
        in_s = '0; run(4);
        edge_s = 1'b1;
        in_s = 4'b0001; tick(); in_s = '0; run(2); in_s = 4'b0001; tick();
        in_s = '0; tick(); in_s = 4'b0001; tick(); in_s = '0; run(8);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                width_s   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                        : 8'($urandom_range(0, 6));
                holdoff_s = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                        : 8'($urandom_range(0, 4));
                retrig_s  = 1'($urandom_range(0, 1));
                edge_s    = 1'($urandom_range(0, 1));
            end
            for (int ch = 0; ch < CH; ch++) in_s[ch] = ($urandom_range(0, 3) == 0);
            nrst_s = ($urandom_range(0, 299) != 0);
            tick();
        end
        nrst_s = 1'b1; in_s = '0; width_s = 8'd3; holdoff_s = 8'd0;
        run(2);

        k = 0;
        while (q.size() > 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
